// File: rtl/vram_fetch_pkg.sv
// Shared types and widths for the VRAM read initiator.
package vram_fetch_pkg;

  localparam int unsigned VRAM_WORD_AW = 15;
  localparam int unsigned VRAM_WORD_W  = 32;
  localparam int unsigned FETCH_CNT_W  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFlush
  } fetch_state_e;

endpackage

// File: rtl/vram_fetch_fifo.sv
// Show-ahead FIFO buffering acknowledged VRAM words; flush wins over push and pop.
module vram_fetch_fifo
  import vram_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = VRAM_WORD_W,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CntW-1:0]  occupancy_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Empty pops are dropped, so a push+pop on an empty FIFO only pushes.
  assign do_push = push_i && !flush_i && (count_q != CntW'(DEPTH));
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign occupancy_o = count_q;
  assign head_o      = mem_q[rd_ptr_q];

endmodule

// File: rtl/vram_fetch.sv
// VRAM read initiator: streams a word range through the arbiter into a show-ahead FIFO.
module vram_fetch
  import vram_fetch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [VRAM_WORD_AW-1:0] start_addr_i,
  input  logic [FETCH_CNT_W-1:0]  word_count_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [VRAM_WORD_AW-1:0] bus_addr_o,
  output logic                    bus_strobe_o,
  input  logic                    bus_ack_i,
  input  logic [VRAM_WORD_W-1:0]  bus_rddata_i,
  output logic [VRAM_WORD_W-1:0]  rd_data_o,
  output logic                    rd_valid_o,
  input  logic                    rd_pop_i
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e            state_q, state_d;
  logic [VRAM_WORD_AW-1:0] addr_q, addr_d, addr_next;
  logic [FETCH_CNT_W-1:0]  remaining_q, remaining_d;
  logic                    done_q, done_d;
  logic [CntW-1:0]         occupancy;
  logic                    in_fetch, ack_fetch;

  assign in_fetch  = (state_q == StFetch);
  assign ack_fetch = in_fetch && bus_ack_i;
  assign addr_next = addr_q + VRAM_WORD_AW'(1);

  // The in-flight ack already claims a word and a FIFO slot; rd_pop is left out on purpose.
  assign bus_strobe_o = in_fetch && (remaining_q != FETCH_CNT_W'(ack_fetch)) &&
                        ((occupancy + CntW'(ack_fetch)) < CntW'(FIFO_DEPTH));
  assign bus_addr_o   = in_fetch ? (bus_ack_i ? addr_next : addr_q) : '0;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i && !abort_i && (word_count_i != '0)) begin
          state_d     = StFetch;
          addr_d      = start_addr_i;
          remaining_d = word_count_i;
        end
      end
      StFetch: begin
        if (abort_i) begin
          state_d = StFlush;
        end else if (bus_ack_i) begin
          addr_d      = addr_next;
          remaining_d = remaining_q - FETCH_CNT_W'(1);
          if (remaining_q == FETCH_CNT_W'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  vram_fetch_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(VRAM_WORD_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (ack_fetch && !abort_i),
    .wdata_i    (bus_rddata_i),
    .pop_i      (rd_pop_i),
    .flush_i    (abort_i),
    .occupancy_o(occupancy),
    .head_o     (rd_data_o)
  );

  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign rd_valid_o = (occupancy != '0);

endmodule

// File: tb/tb_vram_fetch.sv
// Directed bench for vram_fetch with an arbiter model and a word scoreboard.
module tb_vram_fetch;

  localparam int unsigned Depth = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [14:0] start_addr_i;
  logic [8:0]  word_count_i;
  logic        abort_i;
  logic        busy_o, done_o, bus_strobe_o, bus_ack_i, rd_valid_o, rd_pop_i;
  logic [14:0] bus_addr_o;
  logic [31:0] bus_rddata_i, rd_data_o;

  always #5 clk_i = ~clk_i;

  vram_fetch #(.FIFO_DEPTH(Depth)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .start_addr_i(start_addr_i),
    .word_count_i(word_count_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .bus_addr_o  (bus_addr_o),
    .bus_strobe_o(bus_strobe_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rddata_i(bus_rddata_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .rd_pop_i    (rd_pop_i)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [14:0] slog[$];
  bit          live;
  bit          chk_occ;
  int          deny_left;
  logic [14:0] deny_addr;
  int          cyc, done_at, n_pop;
  logic        s_strobe, s_busy, s_done, s_valid;
  logic [14:0] s_addr;

  function automatic logic [31:0] dat(input logic [14:0] a);
    return {a, 2'b10, a} ^ 32'h5A3C_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle at the falling edge, model the arbiter, advance to the next cycle.
  task automatic cycle();
    bit          na;
    logic [31:0] nd;
    int          occ;
    @(negedge clk_i);
    occ      = exp_q.size();
    s_strobe = bus_strobe_o;
    s_addr   = bus_addr_o;
    s_busy   = busy_o;
    s_done   = done_o;
    s_valid  = rd_valid_o;
    if (rd_valid_o && rd_pop_i && !abort_i && !rst_i) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else begin
        chk("rd_data", rd_data_o, exp_q.pop_front());
        n_pop++;
      end
    end
    if (chk_occ) begin
      chk("occ_le_depth", 32'(occ <= Depth), 32'd1);
      if (bus_strobe_o) chk("strobe_has_room", 32'(occ < Depth), 32'd1);
    end
    na = 1'b0;
    if (bus_strobe_o) begin
      slog.push_back(bus_addr_o);
      if (deny_left > 0 && bus_addr_o == deny_addr) deny_left--;
      else na = 1'b1;
    end
    nd = dat(bus_addr_o);
    if (done_o && done_at < 0) done_at = cyc;
    @(posedge clk_i);
    #1;
    bus_ack_i    = na;
    bus_rddata_i = na ? nd : 32'hDEAD_BEEF;
    if (na && live) exp_q.push_back(nd);
    cyc++;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && done_at < 0; i++) cycle();
    if (done_at < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch(input logic [14:0] a, input logic [8:0] n, input int limit);
    slog.delete();
    done_at = -1;
    cyc = 0;
    n_pop = 0;
    start_i = 1'b1;
    start_addr_i = a;
    word_count_i = n;
    cycle();
    start_i = 1'b0;
    wait_done(limit);
  endtask

  task automatic drain();
    rd_pop_i = 1'b1;
    repeat (Depth + 4) cycle();
    rd_pop_i = 1'b0;
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(rd_valid_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    start_addr_i = '0;
    word_count_i = '0;
    abort_i = 1'b0;
    bus_ack_i = 1'b0;
    bus_rddata_i = '0;
    rd_pop_i = 1'b0;
    live = 1'b1;
    chk_occ = 1'b0;
    deny_left = 0;
    deny_addr = '0;
    done_at = -1;
    cyc = 0;
    n_pop = 0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_strobe", 32'(bus_strobe_o), 32'd0);
    chk("rst_addr", 32'(bus_addr_o), 32'd0);
    chk("rst_valid", 32'(rd_valid_o), 32'd0);
    rst_i = 1'b0;
    cycle();

    // Uncontested fetch, cycle-exact.
    slog.delete();
    start_i = 1'b1;
    start_addr_i = 15'h0100;
    word_count_i = 9'd4;
    cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cycle();
      chk($sformatf("t1_strobe_c%0d", c), 32'(s_strobe), 32'(c <= 4));
      if (c <= 4) chk($sformatf("t1_addr_c%0d", c), 32'(s_addr), 32'h100 + 32'(c - 1));
      chk($sformatf("t1_busy_c%0d", c), 32'(s_busy), 32'(c <= 5));
      chk($sformatf("t1_done_c%0d", c), 32'(s_done), 32'(c == 6));
      chk($sformatf("t1_valid_c%0d", c), 32'(s_valid), 32'(c >= 3));
    end
    n_pop = 0;
    drain();
    chk("t1_npop", 32'(n_pop), 32'd4);

    // Second strobe denied twice.
    deny_addr = 15'h0101;
    deny_left = 2;
    fetch(15'h0100, 9'd4, 20);
    chk("t2_done_at", 32'(done_at), 32'd8);
    chk("t2_nstrobe", 32'(slog.size()), 32'd6);
    begin
      logic [14:0] want[6];
      want = '{15'h100, 15'h101, 15'h101, 15'h101, 15'h102, 15'h103};
      for (int i = 0; i < 6 && i < slog.size(); i++)
        chk($sformatf("t2_addr%0d", i), 32'(slog[i]), 32'(want[i]));
    end
    drain();
    chk("t2_npop", 32'(n_pop), 32'd4);

    // Address wrap.
    fetch(15'h7FFE, 9'd4, 20);
    chk("t3_done_at", 32'(done_at), 32'd6);
    begin
      logic [14:0] want[4];
      want = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
      chk("t3_nstrobe", 32'(slog.size()), 32'd4);
      for (int i = 0; i < 4 && i < slog.size(); i++)
        chk($sformatf("t3_addr%0d", i), 32'(slog[i]), 32'(want[i]));
    end
    drain();
    chk("t3_npop", 32'(n_pop), 32'd4);

    // FIFO back-pressure with 20 words.
    chk_occ = 1'b1;
    slog.delete();
    done_at = -1;
    cyc = 0;
    n_pop = 0;
    start_i = 1'b1;
    start_addr_i = 15'h0400;
    word_count_i = 9'd20;
    cycle();
    start_i = 1'b0;
    repeat (14) cycle();
    chk("t4_stalled_strobe", 32'(s_strobe), 32'd0);
    chk("t4_nstrobe", 32'(slog.size()), 32'(Depth));
    chk("t4_busy", 32'(s_busy), 32'd1);
    chk("t4_valid", 32'(s_valid), 32'd1);
    rd_pop_i = 1'b1;
    wait_done(80);
    drain();
    chk_occ = 1'b0;
    chk("t4_npop", 32'(n_pop), 32'd20);
    chk("t4_nstrobe_all", 32'(slog.size()), 32'd20);

    // Abort the cycle after a strobe, with words already buffered.
    slog.delete();
    start_i = 1'b1;
    start_addr_i = 15'h0200;
    word_count_i = 9'd6;
    cycle();
    start_i = 1'b0;
    repeat (3) cycle();
    abort_i = 1'b1;
    live = 1'b0;
    cycle();
    chk("t5_valid_before", 32'(s_valid), 32'd1);
    chk("t5_strobe_before", 32'(s_strobe), 32'd1);
    exp_q.delete();
    abort_i = 1'b0;
    cycle();
    chk("t5_flush_busy", 32'(s_busy), 32'd1);
    chk("t5_flush_valid", 32'(s_valid), 32'd0);
    chk("t5_flush_strobe", 32'(s_strobe), 32'd0);
    chk("t5_flush_done", 32'(s_done), 32'd0);
    cycle();
    chk("t5_idle_busy", 32'(s_busy), 32'd0);
    chk("t5_late_ack_valid", 32'(s_valid), 32'd0);
    chk("t5_idle_done", 32'(s_done), 32'd0);
    live = 1'b1;
    fetch(15'h0300, 9'd2, 10);
    chk("t5_refetch_done_at", 32'(done_at), 32'd4);
    drain();
    chk("t5_npop", 32'(n_pop), 32'd2);

    // Zero word count is ignored.
    start_i = 1'b1;
    start_addr_i = 15'h0123;
    word_count_i = 9'd0;
    cycle();
    start_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      cycle();
      chk($sformatf("t6_busy_c%0d", c), 32'(s_busy), 32'd0);
      chk($sformatf("t6_strobe_c%0d", c), 32'(s_strobe | s_done), 32'd0);
    end

    // Start while busy is ignored.
    slog.delete();
    done_at = -1;
    cyc = 0;
    n_pop = 0;
    start_i = 1'b1;
    start_addr_i = 15'h0040;
    word_count_i = 9'd3;
    cycle();
    start_i = 1'b0;
    cycle();
    start_i = 1'b1;
    start_addr_i = 15'h0555;
    word_count_i = 9'd5;
    cycle();
    start_i = 1'b0;
    wait_done(10);
    chk("t7_done_at", 32'(done_at), 32'd5);
    chk("t7_nstrobe", 32'(slog.size()), 32'd3);
    if (slog.size() == 3) chk("t7_last_addr", 32'(slog[2]), 32'h42);
    cycle();
    chk("t7_idle_after", 32'(s_busy), 32'd0);
    drain();
    chk("t7_npop", 32'(n_pop), 32'd3);

    // Pops on an empty FIFO leave no underflow behind.
    rd_pop_i = 1'b1;
    repeat (3) cycle();
    rd_pop_i = 1'b0;
    fetch(15'h0777, 9'd1, 10);
    chk("t8_valid", 32'(rd_valid_o), 32'd1);
    drain();
    chk("t8_npop", 32'(n_pop), 32'd1);

    // Reset mid-fetch; the ack already in flight must be ignored.
    start_i = 1'b1;
    start_addr_i = 15'h0600;
    word_count_i = 9'd8;
    cycle();
    start_i = 1'b0;
    repeat (2) cycle();
    live = 1'b0;
    rst_i = 1'b1;
    #1;
    chk("t9_rst_busy", 32'(busy_o), 32'd0);
    chk("t9_rst_strobe", 32'(bus_strobe_o), 32'd0);
    chk("t9_rst_addr", 32'(bus_addr_o), 32'd0);
    chk("t9_rst_valid", 32'(rd_valid_o), 32'd0);
    rst_i = 1'b0;
    cycle();
    cycle();
    chk("t9_ack_ignored_valid", 32'(s_valid), 32'd0);
    chk("t9_ack_ignored_busy", 32'(s_busy), 32'd0);
    exp_q.delete();
    live = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
